syn_fifo: RTL

SYN_FIFO -- requirements
Module: syn_fifo

---
 rtl/syn_fifo.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/syn_fifo.sv
// -----------------------------------------------------------------------------
// syn_fifo -- single-clock first-in first-out buffer with registered read data.
//
// Parameters
//   DEPTH : number of storage entries (power of two, >= 2)
//   WIDTH : data bits per entry
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   asynchronous active-high reset
//   we        in   write request
//   re        in   read request
//   din       in   write data [WIDTH-1:0]
//   dout      out  read data, registered, loads one clock after an accepted read
//   full      out  occupancy == DEPTH (registered)
//   empty     out  occupancy == 0 (registered)
//   count     out  occupancy [$clog2(DEPTH):0]
//   overflow  out  one-cycle pulse after a write dropped because full (re=0)
//   underflow out  one-cycle pulse after a read dropped because empty
//
// Build option
//   SYN_FIFO_ERR_FLAGS_EN : when defined, overflow/underflow are registered
//   pulses; when undefined they are tied to 0 and no flag logic exists.
//
// Handshake: a write is taken on an edge where we=1 and the FIFO is not full,
// or it is full but a read is taken on the same edge. A read is taken on an
// edge where re=1 and the FIFO is not empty; dout shows that entry after the
// edge and holds it until the next taken read. Dropped requests change nothing.
// -----------------------------------------------------------------------------
module syn_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] dout_q,   dout_d;
  logic             full_q,   full_d;
  logic             empty_q,  empty_d;

  logic wr_acc;
  logic rd_acc;

  // A write while full is still taken when the same edge frees a slot.
  assign rd_acc = re & ~empty_q;
  assign wr_acc = we & (~full_q | re);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;

    // Pointers are AW bits wide and DEPTH is a power of two, so the natural
    // wrap of the increment gives modulo-DEPTH addressing with no bubble.
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = mem_q[rd_ptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is not reset; after reset the pointers and count make stale
  // entries unreachable. When full with a simultaneous read and write the
  // read above sees the old contents, which is the oldest entry.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end

`ifdef SYN_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = we & ~re & full_q;
    unf_d = re & empty_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign dout  = dout_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule
